// File: rtl/sort_sched_if.sv
// Requester, response and sorter-side signals of the sort job scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface sort_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_CNT   = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]                     req;
  logic [NUM_REQ*DATA_CNT*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                     gnt;
  logic [NUM_REQ-1:0]                     rsp_valid;
  logic [NUM_REQ-1:0]                     rsp_ready;
  logic [DATA_CNT*DATA_WIDTH-1:0]         rsp_data;
  logic                                   rsp_err;
  logic                                   write_en;
  logic [DATA_WIDTH-1:0]                  write_data   [DATA_CNT-1:0];
  logic                                   compare_en;
  logic [DATA_WIDTH-1:0]                  compare_data [DATA_CNT-1:0];
  logic                                   busy;

  modport slave (
    input  req, req_data, rsp_ready, compare_en, compare_data,
    output gnt, rsp_valid, rsp_data, rsp_err, write_en, write_data, busy
  );

  modport master (
    output req, req_data, rsp_ready, compare_en, compare_data,
    input  gnt, rsp_valid, rsp_data, rsp_err, write_en, write_data, busy
  );
endinterface

// File: rtl/sort_sched.sv
// Round-robin scheduler that hands one requester's job at a time to an external
// sorter, waits (with timeout) for its result and returns it to the job owner.
module sort_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_CNT   = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 255
) (
  input logic         clk,
  input logic         rst_n,
  sort_sched_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int VW = DATA_CNT * DATA_WIDTH;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_d;
  logic [PW-1:0]         rr_ptr, rr_ptr_d, owner, owner_d;
  logic [15:0]           wait_cnt, wait_cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic                  write_en_q, write_en_d, rsp_err_q, rsp_err_d, busy_q, busy_d;
  logic [VW-1:0]         rsp_data_q, rsp_data_d;
  logic [DATA_WIDTH-1:0] write_data_q [DATA_CNT-1:0];
  logic [DATA_WIDTH-1:0] write_data_d [DATA_CNT-1:0];
  logic                  pick_ok;
  logic [PW-1:0]         pick;

  // Requester index k positions after base, wrapping at NUM_REQ.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return sum[PW-1:0];
  endfunction

  // Scan from the farthest candidate back to rr_ptr so the nearest active request wins.
  always_comb begin
    pick_ok = 1'b0;
    pick    = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req[rr_idx(rr_ptr, k)]) begin
        pick_ok = 1'b1;
        pick    = rr_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold/idle value first so no path leaves one unassigned (no latches).
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    owner_d      = owner;
    wait_cnt_d   = wait_cnt;
    gnt_d        = '0;
    write_en_d   = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    write_data_d = write_data_q;

    case (state)
      IDLE: if (pick_ok) begin
        state_d    = ISSUE;
        owner_d    = pick;
        gnt_d      = ONE << pick;
        write_en_d = 1'b1;
        for (int i = 0; i < DATA_CNT; i++)
          write_data_d[i] = bus.req_data[(int'(pick) * DATA_CNT + i) * DATA_WIDTH +: DATA_WIDTH];
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
        rr_ptr_d   = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
      WAIT: begin
        // A result arriving on the timeout cycle itself still counts as a result.
        if (bus.compare_en) begin
          state_d     = RESP;
          rsp_valid_d = ONE << owner;
          rsp_err_d   = 1'b0;
          for (int i = 0; i < DATA_CNT; i++)
            rsp_data_d[i * DATA_WIDTH +: DATA_WIDTH] = bus.compare_data[i];
        end else if (wait_cnt == 16'(TIMEOUT)) begin
          state_d     = RESP;
          rsp_valid_d = ONE << owner;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt + 16'd1;
        end
      end
      RESP: if (bus.rsp_ready[owner]) begin
        state_d     = IDLE;
        rsp_valid_d = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      wait_cnt     <= '0;
      gnt_q        <= '0;
      write_en_q   <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      // NOTE: the job buffer is a small register bank, so it is cleared like any other flop.
      write_data_q <= '{default: '0};
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      owner        <= owner_d;
      wait_cnt     <= wait_cnt_d;
      gnt_q        <= gnt_d;
      write_en_q   <= write_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      write_data_q <= write_data_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.write_en   = write_en_q;
  assign bus.write_data = write_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = busy_q;
endmodule
